// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: shadows EX/MEM/WB destinations, detects RAW hazards in ID.
// Define HAZARD_FWD_EN when EX/MEM forwarding exists (only load-use stalls); otherwise EX/MEM hits stall.
module hazard_ctrl #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic              id_rs_v_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rt_v_i,
  input  logic              id_wr_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_ld_i,
  input  logic              br_taken_i,
  input  logic              mem_stall_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pipe_en_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } shadow_t;

  // Index 0 = EX, 1 = MEM, 2 = WB. WB is tracked but never stalls: the regfile writes before it reads.
  shadow_t          shd_q [3];
  shadow_t          shd_d [3];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_ex;
  logic             hazard;
  logic             raw_stall;

  function automatic logic src_hit(input shadow_t s,
                                   input logic [REG_AW-1:0] rs, input logic rs_v,
                                   input logic [REG_AW-1:0] rt, input logic rt_v);
    return (rs_v & s.v & s.wr & (s.rd == rs)) | (rt_v & s.v & s.wr & (s.rd == rt));
  endfunction

  assign hit_ex = src_hit(shd_q[0], id_rs_i, id_rs_v_i, id_rt_i, id_rt_v_i);

`ifdef HAZARD_FWD_EN
  assign hazard = hit_ex & shd_q[0].ld;
`else
  assign hazard = hit_ex | src_hit(shd_q[1], id_rs_i, id_rs_v_i, id_rt_i, id_rt_v_i);
`endif

  assign raw_stall   = id_valid_i & hazard;
  assign stall_cnt_o = cnt_q;

  // Priority: memory freeze beats branch kill beats RAW stall.
  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_en_o     = 1'b1;
    if (mem_stall_i) begin
      pc_en_o   = 1'b0;
      ifid_en_o = 1'b0;
      pipe_en_o = 1'b0;
    end else if (br_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (raw_stall) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  always_comb begin
    shd_d = shd_q;
    cnt_d = cnt_q;
    if (pipe_en_o) begin
      shd_d[2] = shd_q[1];
      shd_d[1] = shd_q[0];
      shd_d[0] = idex_bubble_o ? '0 : {id_valid_i, id_wr_i, id_rd_i, id_ld_i};
    end
    if (raw_stall && !mem_stall_i && !br_taken_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) shd_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      shd_q <= shd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; expectations follow HAZARD_FWD_EN when it is defined.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_rs_v, id_rt_v, id_wr, id_ld, br_taken, mem_stall;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
  logic [15:0] stall_cnt;
  logic        pc_en2, ifid_en2, ifid_flush2, idex_bubble2, pipe_en2;
  logic [1:0]  stall_cnt2;
  logic [4:0]  ov;

  int total = 0;
  int bad   = 0;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [4:0] RUN    = 5'b11001;
  localparam logic [4:0] STALL  = 5'b00011;
  localparam logic [4:0] FLUSH  = 5'b11111;
  localparam logic [4:0] FREEZE = 5'b00000;

  assign ov = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_v_i(id_rs_v),
    .id_rt_i(id_rt), .id_rt_v_i(id_rt_v), .id_wr_i(id_wr), .id_rd_i(id_rd), .id_ld_i(id_ld),
    .br_taken_i(br_taken), .mem_stall_i(mem_stall), .pc_en_o(pc_en), .ifid_en_o(ifid_en),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble), .pipe_en_o(pipe_en),
    .stall_cnt_o(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used to exercise saturation.
  hazard_ctrl #(.REG_AW(3), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_v_i(id_rs_v),
    .id_rt_i(id_rt), .id_rt_v_i(id_rt_v), .id_wr_i(id_wr), .id_rd_i(id_rd), .id_ld_i(id_ld),
    .br_taken_i(br_taken), .mem_stall_i(mem_stall), .pc_en_o(pc_en2), .ifid_en_o(ifid_en2),
    .ifid_flush_o(ifid_flush2), .idex_bubble_o(idex_bubble2), .pipe_en_o(pipe_en2),
    .stall_cnt_o(stall_cnt2)
  );

  task automatic set_id(input logic v, input logic [2:0] rs, input logic rsv,
                        input logic [2:0] rt, input logic rtv, input logic wr,
                        input logic [2:0] rd, input logic ld);
    id_valid = v; id_rs = rs; id_rs_v = rsv; id_rt = rt; id_rt_v = rtv;
    id_wr = wr; id_rd = rd; id_ld = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    br_taken = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL rst_outputs got=%b exp=%b", ov, RUN); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    mem_stall = 1'b1; #1;
    total++; if (ov !== FREEZE) begin bad++; $display("[TB] FAIL rst_memstall got=%b exp=%b", ov, FREEZE); end
    mem_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); set_id(1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 1); #1;
    @(negedge clk); set_id(1, 3'd3, 1, 3'd1, 1, 1, 3'd5, 0); #1;
    total++; if (ov !== STALL) begin bad++; $display("[TB] FAIL mid_prestall got=%b exp=%b", ov, STALL); end
    #1 rst = 1'b1; #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL mid_reset got=%b exp=%b", ov, RUN); end
    rst = 1'b0; #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL mid_release got=%b exp=%b", ov, RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); set_id(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 1); #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL lu_issue got=%b exp=%b", ov, RUN); end
    @(negedge clk); set_id(1, 3'd2, 1, 3'd1, 1, 1, 3'd4, 0); #1;
    total++; if (ov !== STALL) begin bad++; $display("[TB] FAIL lu_stall got=%b exp=%b", ov, STALL); end
    @(negedge clk); #1;
    total++; if (ov !== (FWD ? RUN : STALL)) begin bad++; $display("[TB] FAIL lu_second got=%b exp=%b", ov, FWD ? RUN : STALL); end
    @(negedge clk); #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL lu_resume got=%b exp=%b", ov, RUN); end
    total++; if (stall_cnt !== (FWD ? 16'd1 : 16'd2)) begin bad++; $display("[TB] FAIL lu_cnt got=%0d exp=%0d", stall_cnt, FWD ? 1 : 2); end
  endtask

  task automatic test_alu_dep();
    int nb;
    nb = 0;
    do_reset();
    @(negedge clk); set_id(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_id(1, 3'd2, 1, 3'd2, 1, 1, 3'd5, 0); #1;
      if (idex_bubble === 1'b1) nb++;
    end
    total++; if (nb !== (FWD ? 0 : 2)) begin bad++; $display("[TB] FAIL alu_bubbles got=%0d exp=%0d", nb, FWD ? 0 : 2); end
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL alu_after got=%b exp=%b", ov, RUN); end
    total++; if (stall_cnt !== (FWD ? 16'd0 : 16'd2)) begin bad++; $display("[TB] FAIL alu_cnt got=%0d exp=%0d", stall_cnt, FWD ? 0 : 2); end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk); set_id(1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 1); #1;
    @(negedge clk); set_id(1, 3'd3, 1, 3'd0, 0, 1, 3'd6, 0); br_taken = 1'b1; #1;
    total++; if (ov !== FLUSH) begin bad++; $display("[TB] FAIL br_flush got=%b exp=%b", ov, FLUSH); end
    @(negedge clk); idle(); #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL br_after got=%b exp=%b", ov, RUN); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL br_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    @(negedge clk); set_id(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 1); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_id(1, 3'd2, 1, 3'd1, 1, 1, 3'd4, 0); mem_stall = 1'b1; #1;
      total++; if (ov !== FREEZE) begin bad++; $display("[TB] FAIL ms_freeze%0d got=%b exp=%b", i, ov, FREEZE); end
    end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL ms_cnthold got=%0d exp=0", stall_cnt); end
    @(negedge clk); mem_stall = 1'b0; #1;
    total++; if (ov !== STALL) begin bad++; $display("[TB] FAIL ms_resume got=%b exp=%b", ov, STALL); end
    @(negedge clk); #1;
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("[TB] FAIL ms_cnt got=%0d exp=1", stall_cnt); end
    total++; if (ov !== (FWD ? RUN : STALL)) begin bad++; $display("[TB] FAIL ms_next got=%b exp=%b", ov, FWD ? RUN : STALL); end
  endtask

  task automatic test_no_false_stall();
    do_reset();
    @(negedge clk); set_id(1, 3'd0, 0, 3'd0, 0, 1, 3'd6, 1); #1;
    @(negedge clk); set_id(0, 3'd6, 1, 3'd0, 0, 1, 3'd1, 0); #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL nf_novalid got=%b exp=%b", ov, RUN); end
    set_id(1, 3'd6, 0, 3'd1, 1, 0, 3'd7, 0); #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL nf_rsv0 got=%b exp=%b", ov, RUN); end
    @(negedge clk); set_id(1, 3'd7, 1, 3'd0, 0, 1, 3'd2, 0); #1;
    total++; if (ov !== RUN) begin bad++; $display("[TB] FAIL nf_nowr got=%b exp=%b", ov, RUN); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL nf_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_saturate();
    int guard;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); set_id(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 1); #1;
      @(negedge clk); set_id(1, 3'd1, 1, 3'd0, 0, 0, 3'd0, 0); #1;
      guard = 0;
      while (pc_en !== 1'b1 && guard < 4) begin
        @(negedge clk); #1;
        guard++;
      end
      total++; if (guard >= 4) begin bad++; $display("[TB] FAIL sat_timeout%0d got=%0d exp<4", i, guard); end
    end
    total++; if (stall_cnt2 !== 2'd3) begin bad++; $display("[TB] FAIL sat_cnt2 got=%0d exp=3", stall_cnt2); end
    total++; if (stall_cnt !== (FWD ? 16'd5 : 16'd10)) begin bad++; $display("[TB] FAIL sat_cnt16 got=%0d exp=%0d", stall_cnt, FWD ? 5 : 10); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_load_use();
    test_alu_dep();
    test_branch();
    test_mem_stall();
    test_no_false_stall();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
